// File: rtl/debug_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debug_scanner_pkg : opcodes, FSM encoding and defaults for debug_scanner |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package debug_scanner_pkg;

  localparam int c_dump_last_default = 55;
  localparam int c_addr_w            = 7;
  localparam int c_data_w            = 32;

  localparam logic [1:0] c_op_run  = 2'b00;
  localparam logic [1:0] c_op_halt = 2'b01;
  localparam logic [1:0] c_op_step = 2'b10;
  localparam logic [1:0] c_op_dump = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STEP_HI  = 3'd1,
    ST_STEP_LO  = 3'd2,
    ST_DUMP_SET = 3'd3,
    ST_DUMP_OUT = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/debug_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debug_step_gen : step counter and STEP_HI/STEP_LO pulse sequencing       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module debug_step_gen
  import debug_scanner_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] count,
  input  state_e            cur_state,
  input  state_e            nxt_state,
  output state_e            step_next,
  output logic              debug_step
);

  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              debug_step_q, debug_step_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = count;
    end else if (cur_state == ST_STEP_LO) begin
      cnt_d = cnt_q - STEP_W'(1);
    end
  end

  // The decrement lands at the end of STEP_LO, so a count of one is the last pulse.
  always_comb begin
    step_next = ST_IDLE;
    case (cur_state)
      ST_STEP_HI: step_next = ST_STEP_LO;
      ST_STEP_LO: step_next = (cnt_q == STEP_W'(1)) ? ST_IDLE : ST_STEP_HI;
      default:    step_next = ST_IDLE;
    endcase
  end

  assign debug_step_d = (nxt_state == ST_STEP_HI);
  assign debug_step   = debug_step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      debug_step_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      debug_step_q <= debug_step_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debug_scanner : command-driven CPU halt/step/dump controller             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module debug_scanner
  import debug_scanner_pkg::*;
#(
  parameter int DUMP_LAST = c_dump_last_default,
  parameter int STEP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [STEP_W-1:0]   cmd_arg,
  output logic                debug_en,
  output logic                debug_step,
  output logic [c_addr_w-1:0] debug_addr,
  input  logic [c_data_w-1:0] debug_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [c_addr_w-1:0] out_addr,
  output logic [c_data_w-1:0] out_data,
  output logic                out_last
);

  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(DUMP_LAST);

  state_e              state_q, state_d, step_next;
  logic                debug_en_q, debug_en_d;
  logic [c_addr_w-1:0] debug_addr_q, debug_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [c_addr_w-1:0] out_addr_q, out_addr_d;
  logic [c_data_w-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                step_load;

  assign cmd_ready = (state_q == ST_IDLE);
  assign step_load = cmd_ready && cmd_valid && (cmd_op == c_op_step) && (cmd_arg != '0);

  debug_step_gen #(
    .STEP_W (STEP_W)
  ) u_step_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (step_load),
    .count      (cmd_arg),
    .cur_state  (state_q),
    .nxt_state  (state_d),
    .step_next  (step_next),
    .debug_step (debug_step)
  );

  always_comb begin
    state_d      = state_q;
    debug_en_d   = debug_en_q;
    debug_addr_d = debug_addr_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            c_op_run:  debug_en_d = 1'b0;
            c_op_halt: debug_en_d = 1'b1;
            c_op_step: begin
              debug_en_d = 1'b1;
              if (step_load) state_d = ST_STEP_HI;
            end
            default: begin
              debug_en_d   = 1'b1;
              debug_addr_d = '0;
              state_d      = ST_DUMP_SET;
            end
          endcase
        end
      end
      ST_STEP_HI, ST_STEP_LO: state_d = step_next;
      // Address has been stable on the core for a full cycle; capture the read.
      ST_DUMP_SET: begin
        out_data_d  = debug_data;
        out_addr_d  = debug_addr_q;
        out_last_d  = (debug_addr_q == c_last_addr);
        out_valid_d = 1'b1;
        state_d     = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            debug_addr_d = debug_addr_q + c_addr_w'(1);
            state_d      = ST_DUMP_SET;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      debug_en_q   <= 1'b0;
      debug_addr_q <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      debug_en_q   <= debug_en_d;
      debug_addr_q <= debug_addr_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign debug_en   = debug_en_q;
  assign debug_addr = debug_addr_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debug_scanner : scoreboard bench for debug_scanner                    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_debug_scanner;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_arg = 8'd0;
  logic        debug_en, debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  int    checks = 0;
  int    failures = 0;
  int    pc = 0;
  int    ready_mode = 0;
  word_t exp_q[$];

  debug_scanner #(.DUMP_LAST(55), .STEP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Core model: register file reads back addr*4; PC fetches when running or stepped.
  assign debug_data = {23'd0, debug_addr, 2'b00};

  initial forever begin
    @(posedge clk);
    if (!rst && (!debug_en || debug_step)) pc = pc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (($time / 10) % 3) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    logic        stall_prev = 1'b0;
    logic [6:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;
    word_t       e;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, p_data);
        chk("stall_addr", {25'd0, out_addr}, {25'd0, p_addr});
        chk("stall_last", {31'd0, out_last}, {31'd0, p_last});
      end
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("dump_unexpected_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dump_addr", {25'd0, out_addr}, {25'd0, e.addr});
          chk("dump_data", out_data, e.data);
          chk("dump_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      stall_prev = out_valid && !out_ready && !rst;
      p_addr = out_addr;
      p_data = out_data;
      p_last = out_last;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    int n = 0;
    bit done = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!done && n < 1000) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
      else n++;
    end
    if (done) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_dump();
    word_t e;
    for (int a = 0; a <= 55; a++) begin
      e.addr = 7'(a);
      e.data = 32'(a * 4);
      e.last = (a == 55);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!cmd_ready && cycles < 2000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int p0;
    int bad;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_debug_en", {31'd0, debug_en}, 32'd0);
    chk("rst_debug_step", {31'd0, debug_step}, 32'd0);
    chk("rst_debug_addr", {25'd0, debug_addr}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", {25'd0, out_addr}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    send_cmd(2'b01, 8'd0);
    @(negedge clk);
    chk("halt_debug_en", {31'd0, debug_en}, 32'd1);
    chk("halt_debug_step", {31'd0, debug_step}, 32'd0);
    chk("halt_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    send_cmd(2'b10, 8'd3);
    p0 = pc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) p0 = pc;
      chk($sformatf("step3_pulse_%0d", k), {31'd0, debug_step}, 32'(k % 2));
      chk($sformatf("step3_busy_%0d", k), {31'd0, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    chk("step3_ready_after_6", {31'd0, cmd_ready}, 32'd1);
    chk("step3_pc_advance", 32'(pc - p0), 32'd3);
    chk("step3_debug_en", {31'd0, debug_en}, 32'd1);

    send_cmd(2'b10, 8'd0);
    @(negedge clk);
    chk("step0_ready", {31'd0, cmd_ready}, 32'd1);
    chk("step0_no_pulse", {31'd0, debug_step}, 32'd0);
    chk("step0_debug_en", {31'd0, debug_en}, 32'd1);

    send_cmd(2'b00, 8'd0);
    @(negedge clk);
    chk("run_debug_en", {31'd0, debug_en}, 32'd0);

    ready_mode = 0;
    push_dump();
    send_cmd(2'b11, 8'd0);
    wait_idle(cyc);
    chk("dump_cycles", 32'(cyc), 32'd112);
    chk("dump_all_words", 32'(exp_q.size()), 32'd0);
    chk("dump_debug_en_kept", {31'd0, debug_en}, 32'd1);

    ready_mode = 1;
    push_dump();
    send_cmd(2'b11, 8'd0);
    send_cmd(2'b10, 8'd2);
    chk("held_step_after_dump", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("held_step_pulse", {31'd0, debug_step}, 32'd1);
    wait_idle(cyc);
    chk("held_step_cycles", 32'(cyc), 32'd3);
    ready_mode = 0;
    send_cmd(2'b00, 8'd0);
    @(negedge clk);
    chk("run_after_dump_en", {31'd0, debug_en}, 32'd0);

    send_cmd(2'b10, 8'd10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) chk("rst_step_debug_en", {31'd0, debug_en}, 32'd0);
      if (debug_step) bad++;
    end
    chk("rst_step_no_pulses", 32'(bad), 32'd0);
    chk("rst_step_ready", {31'd0, cmd_ready}, 32'd1);

    ready_mode = 2;
    send_cmd(2'b11, 8'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) chk("rst_dump_out_data", out_data, 32'd0);
      if (out_valid) bad++;
    end
    chk("rst_dump_no_valid", 32'(bad), 32'd0);
    chk("rst_dump_debug_en", {31'd0, debug_en}, 32'd0);

    ready_mode = 0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
